// File: rtl/mul8_share_sched.sv
// mul8_share_sched: round-robin scheduler sharing one external 8x8 multiplier
// among NREQ requesters, with a two-stage operand/response pipeline, a tagged
// valid/ready response stream and a flush/drain FSM.
// Optional build macro: MUL_ERR_MON_EN adds an error monitor (err_clr,
// err_cnt, err_max) comparing mul_o against the exact product.
module mul8_share_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_o,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [15:0]       rsp_prod,
    input  logic              rsp_ready,
    input  logic              flush,
    output logic              flush_done,
    output logic              busy
`ifdef MUL_ERR_MON_EN
    ,
    input  logic              err_clr,
    output logic [15:0]       err_cnt,
    output logic [15:0]       err_max
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_hold, w_hold_nxt;
    logic            r_flush_done, w_done_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic            r_s1_valid;
    logic [7:0]      r_mul_a, r_mul_b;
    logic [ID_W-1:0] r_s1_id;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic [15:0]     r_rsp_prod;

    logic            w_s2_free, w_s1_free;
    logic            w_hi_found, w_lo_found;
    logic [ID_W-1:0] w_hi_idx, w_lo_idx, w_gnt_idx;
    logic            w_gnt_found, w_accept;
    logic [7:0]      w_sel_a, w_sel_b;

    assign w_s2_free = !r_rsp_valid || rsp_ready;
    assign w_s1_free = !r_s1_valid || w_s2_free;

    // Round-robin search: first valid index at or above rr_ptr, else lowest valid index.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid[i] && !w_hi_found && (i >= 32'(r_rr_ptr))) begin
                w_hi_found = 1'b1;
                w_hi_idx   = ID_W'(i);
            end
            if (req_valid[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = ID_W'(i);
            end
        end
        w_gnt_found = w_lo_found;
        w_gnt_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // Accept gating, per-requester ready and operand mux for the granted requester.
    always_comb begin
        w_accept = rst_n && w_gnt_found && w_s1_free && (r_state != ST_DRAIN) && !flush;
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                req_ready[i] = w_accept;
                w_sel_a      = req_a[8*i +: 8];
                w_sel_b      = req_b[8*i +: 8];
            end
        end
    end

    // Flush FSM next state; r_hold suppresses a second drain while flush stays high.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_hold_nxt  = r_hold && flush;
        case (r_state)
            ST_IDLE: begin
                if (flush && !r_hold) w_state_nxt = ST_DRAIN;
                else if (w_accept)    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (flush)
                    w_state_nxt = ST_DRAIN;
                else if (!w_accept && !r_s1_valid && !r_rsp_valid)
                    w_state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!r_s1_valid && !r_rsp_valid) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_hold_nxt  = flush;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, drain-hold flag, done pulse and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hold       <= 1'b0;
            r_flush_done <= 1'b0;
            r_rr_ptr     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_flush_done <= w_done_nxt;
            if (w_accept)
                r_rr_ptr <= (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
    end

    // S1 operand stage; operands hold when empty to keep the multiplier quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_s1_id    <= '0;
        end else begin
            r_s1_valid <= w_accept || (r_s1_valid && !w_s2_free);
            if (w_accept) begin
                r_mul_a <= w_sel_a;
                r_mul_b <= w_sel_b;
                r_s1_id <= w_gnt_idx;
            end
        end
    end

    // S2 response stage captures the multiplier output when S1 advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
        end else if (w_s2_free) begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_id   <= r_s1_id;
                r_rsp_prod <= mul_o;
            end
        end
    end

    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_prod   = r_rsp_prod;
    assign flush_done = r_flush_done;
    assign busy       = r_s1_valid || r_rsp_valid;

`ifdef MUL_ERR_MON_EN
    logic [15:0] r_s2_exact;
    logic [15:0] r_err_cnt, r_err_max;
    logic [15:0] w_err_abs;

    assign w_err_abs = (r_rsp_prod >= r_s2_exact) ? (r_rsp_prod - r_s2_exact)
                                                  : (r_s2_exact - r_rsp_prod);

    // Exact product of the S1 operands travels alongside the S2 response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_s2_exact <= '0;
        else if (w_s2_free && r_s1_valid)
            r_s2_exact <= 16'(r_mul_a) * 16'(r_mul_b);
    end

    // Error counters update on delivery; a synchronous clear overrides an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
            r_err_max <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
            r_err_max <= '0;
        end else if (r_rsp_valid && rsp_ready) begin
            if (w_err_abs != 16'd0 && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (w_err_abs > r_err_max)
                r_err_max <= w_err_abs;
        end
    end

    assign err_cnt = r_err_cnt;
    assign err_max = r_err_max;
`endif

endmodule
